// File: rtl/calc_result_acc.sv
// calc_result_acc: accumulates 8x4 grids of partial products across K-tiles
// (mod 2^ACC_W) and drains the finished Y tile row by row over valid/ready.
// Optional build macro CALC_ACC_ROUND_EN: output lanes are rounded and shifted
// right by SHIFT instead of being passed through raw.
//
// state | meaning
// IDLE  | accumulators hold nothing valid; next beat overwrites them
// ACCUM | at least one K-tile accumulated, waiting for more / in_last
// DRAIN | emitting result rows, upstream held off
module calc_result_acc #(
    parameter int ROWS  = 8,
    parameter int COLS  = 4,
    parameter int IN_W  = 17,
    parameter int ACC_W = 16,
    parameter int SHIFT = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    input  logic                                     in_last,
    input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]      partial_in,
    output logic                                     in_ready,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [COLS-1:0][ACC_W-1:0]               out_data,
    output logic [$clog2(ROWS)-1:0]                  out_row,
    output logic                                     out_last,
    output logic [15:0]                              tile_cnt
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

`ifdef CALC_ACC_ROUND_EN
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);
`else
    // SHIFT only matters for the rounding build.
    localparam int SHIFT_UNUSED = SHIFT;
`endif

    logic [1:0]       state;
    logic [RW-1:0]    row_ptr;
    logic [ACC_W-1:0] acc [ROWS][COLS];
    logic             accept;
    logic             unused_hi_bits;

    assign in_ready = (state != DRAIN);
    assign accept   = in_valid && in_ready;

    // Partial bits above ACC_W cannot affect a mod 2^ACC_W sum; sink them.
    always_comb begin
        unused_hi_bits = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                unused_hi_bits = unused_hi_bits ^ (^partial_in[r][c][IN_W-1:ACC_W]);
            end
        end
    end

    // Tile sequencing: load/accumulate grids, then step the row pointer through the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row_ptr  <= '0;
            tile_cnt <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    acc[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                acc[r][c] <= partial_in[r][c][ACC_W-1:0];
                            end
                        end
                        tile_cnt <= 16'd1;
                        state    <= in_last ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                acc[r][c] <= acc[r][c] + partial_in[r][c][ACC_W-1:0];
                            end
                        end
                        if (tile_cnt != 16'hFFFF) begin
                            tile_cnt <= tile_cnt + 16'd1;
                        end
                        if (in_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_ptr == LAST_ROW) begin
                            row_ptr  <= '0;
                            tile_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            row_ptr <= row_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output row view: purely state-derived, so it holds steady under backpressure.
    always_comb begin
        out_valid = (state == DRAIN);
        out_row   = row_ptr;
        out_last  = (state == DRAIN) && (row_ptr == LAST_ROW);
        out_data  = '0;
        if (state == DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
`ifdef CALC_ACC_ROUND_EN
                out_data[c] = (acc[row_ptr][c] + HALF) >> SHIFT;
`else
                out_data[c] = acc[row_ptr][c];
`endif
            end
        end
    end

endmodule

// File: tb/tb_calc_result_acc.sv
// Bench for calc_result_acc: table-driven uniform-grid vectors, hand-written
// backpressure / reset sequences, and randomized multi-tile runs against a
// sum-mod-2^16 reference model.
module tb_calc_result_acc;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_last;
    logic [7:0][3:0][16:0]       partial_in;
    logic                        in_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic [3:0][15:0]            out_data;
    logic [2:0]                  out_row;
    logic                        out_last;
    logic [15:0]                 tile_cnt;

    int vectors = 0;
    int miscompares = 0;

    calc_result_acc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .partial_in(partial_in), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [15:0] grid16_t [8][4];

    typedef struct {
        int          ntiles;
        logic [16:0] lane [3];
        logic [15:0] exp_acc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] out_lane(input logic [15:0] v);
`ifdef CALC_ACC_ROUND_EN
        logic [15:0] t;
        t = v + 16'd128;
        return t >> 8;
`else
        return v;
`endif
    endfunction

    // Present one grid at the next negedge; it is accepted on the following posedge.
    task automatic send_tile(input logic [7:0][3:0][16:0] g, input logic last, input int k);
        @(negedge clk);
        check("in_ready_before_beat", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_last    = last;
        partial_in = g;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("tile_cnt_after_beat", 64'(tile_cnt), 64'(k));
    endtask

    // mode 0: out_ready high; 1: random out_ready; 2: stall 5 cycles at row 3 with in_valid pushed.
    task automatic drain(input grid16_t exp, input int exp_tiles, input int mode);
        int row = 0;
        int cyc = 0;
        int stalls = 0;
        int low = 0;
        int stall_left = 5;
        logic r;
        logic [3:0][15:0] er;
        logic [63:0] held;
        while (row < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: r = 1'b1;
                1: r = ($urandom_range(0, 3) != 0);
                default: begin
                    r = !(row == 3 && stall_left > 0);
                    if (!r) stall_left--;
                end
            endcase
            out_ready = r;
            in_valid  = (mode == 2) && !r;
            if (in_valid) partial_in = '1;
            if (!in_ready) low++;
            for (int c = 0; c < 4; c++) er[c] = out_lane(exp[row][c]);
            check("out_valid_drain", 64'(out_valid), 64'd1);
            check("out_row", 64'(out_row), 64'(row));
            check("out_data", 64'(out_data), 64'(er));
            check("out_last", 64'(out_last), 64'(row == 7));
            check("tile_cnt_drain", 64'(tile_cnt), 64'(exp_tiles));
            if (mode == 2 && !r) begin
                if (stall_left < 4) check("held_data", 64'(out_data), held);
                held = 64'(out_data);
            end
            if (r) row++;
            else stalls++;
        end
        if (row < 8) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d rows, expected 8", row);
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("in_ready_low_cycles", 64'(low), 64'(8 + stalls));
        if (mode == 2) check("stall_cycles", 64'(stalls), 64'd5);
        check("in_ready_after", 64'(in_ready), 64'd1);
        check("out_valid_after", 64'(out_valid), 64'd0);
        check("tile_cnt_after", 64'(tile_cnt), 64'd0);
    endtask

    function automatic logic [7:0][3:0][16:0] uniform(input logic [16:0] v);
        logic [7:0][3:0][16:0] g;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++) g[r][c] = v;
        return g;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        grid16_t exp;
        logic [7:0][3:0][16:0] g;
        int nt;

        vecs[0] = '{1, '{17'h00005, 17'h0, 17'h0}, 16'h0005};
        vecs[1] = '{3, '{17'h00100, 17'h00200, 17'h00300}, 16'h0600};
        vecs[2] = '{2, '{17'h1FFFF, 17'h00002, 17'h0}, 16'h0001};
        vecs[3] = '{2, '{17'h18000, 17'h08000, 17'h0}, 16'h0000};
        vecs[4] = '{1, '{17'h00180, 17'h0, 17'h0}, 16'h0180};
        vecs[5] = '{1, '{17'h0017F, 17'h0, 17'h0}, 16'h017F};
        vecs[6] = '{1, '{17'h0FF80, 17'h0, 17'h0}, 16'hFF80};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; partial_in = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_tile_cnt", 64'(tile_cnt), 64'd0);
        check("rst_out_row", 64'(out_row), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            for (int t = 0; t < vecs[i].ntiles; t++)
                send_tile(uniform(vecs[i].lane[t]), t == vecs[i].ntiles - 1, t + 1);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 4; c++) exp[r][c] = vecs[i].exp_acc;
            drain(exp, vecs[i].ntiles, 0);
        end

        // Backpressure at row 3 with a beat pushed during the stall.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++) begin
                g[r][c] = 17'($urandom);
                exp[r][c] = g[r][c][15:0];
            end
        send_tile(g, 1'b1, 1);
        drain(exp, 1, 2);

        // Reset mid-drain at row 4, then a fresh tile drains cleanly.
        send_tile(uniform(17'h00009), 1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("row_before_reset", 64'(out_row), 64'd4);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_tile_cnt", 64'(tile_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_valid_after_reset", 64'(out_valid), 64'd0);
        send_tile(uniform(17'h00007), 1'b1, 1);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++) exp[r][c] = 16'h0007;
        drain(exp, 1, 0);

        // Randomized multi-tile runs with idle gaps and stray in_last.
        for (int it = 0; it < 20; it++) begin
            nt = $urandom_range(1, 4);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 4; c++) exp[r][c] = 16'h0;
            for (int t = 0; t < nt; t++) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 4; c++) begin
                        g[r][c] = 17'($urandom);
                        exp[r][c] = 16'((32'(exp[r][c]) + 32'(g[r][c])) % 32'h10000);
                    end
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_last = 1'($urandom);
                    partial_in = {8{$urandom, $urandom, $urandom}};
                end
                send_tile(g, t == nt - 1, t + 1);
            end
            drain(exp, nt, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
